// File: rtl/beamformer_pkg.sv
// beamformer_pkg: shared constants and controller encoding for the beamformer control path
package beamformer_pkg;
  localparam int BF_ADDR_W = 11;
  localparam int BF_IDX_W = 16;
  localparam int BF_SLICE_W = 2;
  localparam int SLICE_IDLE = 0;
  localparam int SLICE_FIRST = 1;
  typedef logic [1:0] ctrl_state_t;
  localparam ctrl_state_t ST_IDLE = 2'd0;
  localparam ctrl_state_t ST_ACCUM = 2'd1;
  localparam ctrl_state_t ST_READOUT = 2'd2;
  localparam ctrl_state_t ST_DONE = 2'd3;
endpackage

// File: rtl/beamform_slice_counter.sv
// beamform_slice_counter: slice rotation, sample index and read-in address counters
module beamform_slice_counter
  import beamformer_pkg::*;
#(
  parameter int NUM_SLICES = 3,
  parameter int SLICE_W = BF_SLICE_W,
  parameter int ADDR_W = BF_ADDR_W,
  parameter int IDX_W = BF_IDX_W,
  parameter int NUM_FRAMES = 2048,
  parameter int READ_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               clr_i,
  output logic [SLICE_W-1:0] slice_o,
  output logic [IDX_W-1:0]   index_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               last_o
);
  localparam logic [SLICE_W-1:0] S_IDLE = SLICE_W'(SLICE_IDLE);
  localparam logic [SLICE_W-1:0] S_LAST = SLICE_W'(NUM_SLICES);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(NUM_FRAMES - 1);
  localparam logic [IDX_W-1:0] I_RST = IDX_W'(-READ_LAT);
  logic [SLICE_W-1:0] slice_q, slice_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  assign last_o = slice_q == S_LAST && addr_q == A_LAST;
  assign slice_o = slice_q;
  assign index_o = index_q;
  assign addr_o = addr_q;
  // Next-state: index advances on every active slice, address on the last slice except in the final frame
  always_comb begin
    slice_d = clr_i ? S_IDLE : en_i ? (slice_q == S_LAST ? S_IDLE : slice_q + 1'b1) : slice_q;
    index_d = clr_i ? I_RST : (en_i && slice_q != S_IDLE) ? index_q + 1'b1 : index_q;
    addr_d = clr_i ? '0 : (en_i && slice_q == S_LAST && !last_o) ? addr_q + 1'b1 : addr_q;
  end
  // Counter registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slice_q <= S_IDLE;
      index_q <= I_RST;
      addr_q <= '0;
    end else begin
      slice_q <= slice_d;
      index_q <= index_d;
      addr_q <= addr_d;
    end
endmodule

// File: rtl/beamform_sequencer.sv
// beamform_sequencer: accumulation sequencing and strided sum-buffer readout for the beamformer
module beamform_sequencer
  import beamformer_pkg::*;
#(
  parameter int NUM_SLICES = 3,
  parameter int SLICE_W = BF_SLICE_W,
  parameter int ADDR_W = BF_ADDR_W,
  parameter int IDX_W = BF_IDX_W,
  parameter int NUM_FRAMES = 2048,
  parameter int DEPTH = 2048,
  parameter int READ_LAT = 2,
  parameter int STRIDE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               usedataflag,
  output logic [SLICE_W-1:0] slice_state,
  output logic [IDX_W-1:0]   sample_index,
  output logic [ADDR_W-1:0]  readin_address,
  output logic               readinen,
  output logic [ADDR_W-1:0]  sumout_address,
  output logic               sumouten,
  output logic               busy,
  output logic               done
);
  localparam int STR_W = STRIDE > 1 ? $clog2(STRIDE) : 1;
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRIDE - 1);
  localparam logic [ADDR_W-1:0] SUM_LAST = ADDR_W'(DEPTH - 1);
  ctrl_state_t state_q, state_d;
  logic [ADDR_W-1:0] sum_q, sum_d;
  logic [STR_W-1:0] stride_q, stride_d;
  logic flag_q, fall_q, busy_q, done_q, readinen_q, sumouten_q;
  logic accum, last_frame;
  assign accum = state_q == ST_ACCUM;
  beamform_slice_counter #(
    .NUM_SLICES(NUM_SLICES),
    .SLICE_W(SLICE_W),
    .ADDR_W(ADDR_W),
    .IDX_W(IDX_W),
    .NUM_FRAMES(NUM_FRAMES),
    .READ_LAT(READ_LAT)
  ) u_slice (
    .clk(clk),
    .rst(rst),
    .en_i(accum && !abort),
    .clr_i(abort || state_q == ST_DONE),
    .slice_o(slice_state),
    .index_o(sample_index),
    .addr_o(readin_address),
    .last_o(last_frame)
  );
  assign sumout_address = sum_q;
  assign readinen = readinen_q;
  assign sumouten = sumouten_q;
  assign busy = busy_q;
  assign done = done_q;
  // Controller FSM and sum-buffer address: edge-driven during accumulation, strided during readout
  always_comb begin
    state_d = state_q;
    sum_d = sum_q;
    stride_d = stride_q;
    case (state_q)
      ST_IDLE: state_d = start ? ST_ACCUM : ST_IDLE;
      ST_ACCUM: begin
        sum_d = fall_q ? (sum_q == SUM_LAST ? '0 : sum_q + 1'b1) : sum_q;
        if (last_frame) begin
          state_d = ST_READOUT;
          sum_d = '0;
          stride_d = '0;
        end
      end
      ST_READOUT: begin
        stride_d = stride_q == STR_LAST ? '0 : stride_q + 1'b1;
        if (stride_q == STR_LAST) begin
          if (sum_q == SUM_LAST) state_d = ST_DONE;
          else sum_d = sum_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sum_d = '0;
        stride_d = '0;
      end
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      sum_d = '0;
      stride_d = '0;
    end
  end
  // State, edge-detect pipeline and registered status outputs decoded from the next state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      sum_q <= '0;
      stride_q <= '0;
      flag_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      readinen_q <= 1'b0;
      sumouten_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q <= sum_d;
      stride_q <= stride_d;
      flag_q <= usedataflag;
      fall_q <= flag_q & ~usedataflag & accum;
      busy_q <= state_d == ST_ACCUM || state_d == ST_READOUT;
      done_q <= state_d == ST_DONE;
      readinen_q <= state_d == ST_ACCUM;
      sumouten_q <= state_d == ST_READOUT;
    end
endmodule

// File: tb/tb_beamform_sequencer.sv
// tb_beamform_sequencer: scoreboard bench for the beamform sequencer
module tb_beamform_sequencer;
  localparam int NS = 3;
  localparam int NF = 4;
  localparam int DP = 8;
  localparam int ST = 2;
  localparam int RL = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic usedataflag = 1'b0;
  logic [1:0] slice_state;
  logic [15:0] sample_index;
  logic [10:0] readin_address, sumout_address;
  logic readinen, sumouten, busy, done;
  typedef struct packed {
    logic [1:0] ss;
    logic [15:0] si;
    logic [10:0] ra;
    logic rie;
    logic [10:0] sa;
    logic soe;
    logic bsy;
    logic dn;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  int n_err = 0;
  int n_chk = 0;
  int n_done = 0;
  int n_busy = 0;
  int m_st = 0;
  int m_c = 0;
  int m_sum = 0;
  logic m_fq = 1'b0;
  logic m_fall = 1'b0;
  logic m_nf;
  beamform_sequencer #(
    .NUM_SLICES(NS),
    .SLICE_W(2),
    .ADDR_W(11),
    .IDX_W(16),
    .NUM_FRAMES(NF),
    .DEPTH(DP),
    .READ_LAT(RL),
    .STRIDE(ST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .usedataflag(usedataflag),
    .slice_state(slice_state),
    .sample_index(sample_index),
    .readin_address(readin_address),
    .readinen(readinen),
    .sumout_address(sumout_address),
    .sumouten(sumouten),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic exp_t expect_now();
    exp_t e;
    e = '0;
    e.si = 16'(-RL);
    case (m_st)
      1: begin
        e.ss = 2'(m_c % (NS + 1));
        e.ra = 11'(m_c / (NS + 1));
        e.si = 16'(-RL + m_c - (m_c + NS) / (NS + 1));
        e.rie = 1'b1;
        e.bsy = 1'b1;
        e.sa = 11'(m_sum % DP);
      end
      2: begin
        e.si = 16'(-RL + NF * NS);
        e.ra = 11'(NF - 1);
        e.soe = 1'b1;
        e.bsy = 1'b1;
        e.sa = 11'(m_c / ST);
      end
      3: begin
        e.si = 16'(-RL + NF * NS);
        e.ra = 11'(NF - 1);
        e.sa = 11'(DP - 1);
        e.dn = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction
  // Reference model: advances on each clock from the sampled inputs and queues the expected outputs
  always @(posedge clk) begin
    if (rst) begin
      m_st = 0;
      m_c = 0;
      m_sum = 0;
      m_fq = 1'b0;
      m_fall = 1'b0;
    end else begin
      m_nf = m_fq & ~usedataflag & (m_st == 1);
      if (abort) begin
        m_st = 0;
        m_c = 0;
        m_sum = 0;
      end else begin
        case (m_st)
          0: if (start) begin
            m_st = 1;
            m_c = 0;
            m_sum = 0;
          end
          1: begin
            if (m_fall) m_sum++;
            if (m_c == NF * (NS + 1) - 1) begin
              m_st = 2;
              m_c = 0;
            end else m_c++;
          end
          2: if (m_c == DP * ST - 1) begin
            m_st = 3;
            m_c = 0;
          end else m_c++;
          default: m_st = 0;
        endcase
      end
      m_fall = m_nf;
      m_fq = usedataflag;
    end
    exp_q.push_back(expect_now());
  end
  // Compare DUT outputs against the queued expectation away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check("slice_state", 32'(slice_state), 32'(cur.ss));
      check("sample_index", 32'(sample_index), 32'(cur.si));
      check("readin_address", 32'(readin_address), 32'(cur.ra));
      check("readinen", 32'(readinen), 32'(cur.rie));
      check("sumout_address", 32'(sumout_address), 32'(cur.sa));
      check("sumouten", 32'(sumouten), 32'(cur.soe));
      check("busy", 32'(busy), 32'(cur.bsy));
      check("done", 32'(done), 32'(cur.dn));
    end
    if (done) n_done++;
    if (busy) n_busy++;
  end
  initial begin
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_index", 32'(sample_index), 32'hFFFE);
    check("rst_slice", 32'(slice_state), 32'd0);
    check("rst_sumout", 32'(sumout_address), 32'd0);
    rst = 1'b0;
    tick(2);
    usedataflag = 1'b1;
    tick(2);
    usedataflag = 1'b0;
    tick(3);
    check("idle_edge_ignored", 32'(sumout_address), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    tick(2);
    check("start_abort_idle", 32'(busy), 32'd0);
    n_done = 0;
    n_busy = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    usedataflag = 1'b1;
    tick(2);
    usedataflag = 1'b0;
    tick(2);
    usedataflag = 1'b1;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    usedataflag = 1'b0;
    tick(2);
    usedataflag = 1'b1;
    tick(2);
    usedataflag = 1'b0;
    tick(3);
    check("accum_falls", 32'(sumout_address), 32'd3);
    check("accum_last_index", 32'(sample_index), 32'd9);
    tick(1);
    check("readout_final_index", 32'(sample_index), 32'd10);
    tick(5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(12);
    check("run1_done_count", 32'(n_done), 32'd1);
    check("run1_length", 32'(n_busy), 32'd32);
    n_done = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_index", 32'(sample_index), 32'hFFFE);
    check("abort_readin", 32'(readin_address), 32'd0);
    tick(3);
    check("abort_no_done", 32'(n_done), 32'd0);
    n_done = 0;
    n_busy = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(40);
    check("run3_done_count", 32'(n_done), 32'd1);
    check("run3_length", 32'(n_busy), 32'd32);
    n_done = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(26);
    check("pre_rst_sumout", 32'(sumout_address), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("arst_sumout", 32'(sumout_address), 32'd0);
    check("arst_sumouten", 32'(sumouten), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_index", 32'(sample_index), 32'hFFFE);
    check("arst_readin", 32'(readin_address), 32'd0);
    check("arst_slice", 32'(slice_state), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(3);
    check("arst_no_done", 32'(n_done), 32'd0);
    tick(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/beamform_sequencer.md
Name: beamform_sequencer

Overview:
Parametrised control sequencer for the BRAM delay-and-sum beamformer datapath. It generates the slice-state rotation, sample index, read-in address and sum-out address that the datapath needs during accumulation. It then runs an autonomous strided readout of the summed buffer and reports completion. It replaces the hand-written stimulus sequencing and supports any slice count, frame count, buffer depth, readout stride and BRAM read latency.

Parameters:
NUM_SLICES, 3, number of active slice states per frame (slice states 1..NUM_SLICES; state 0 is the idle/delay slot)
SLICE_W, 2, width of slice_state; must satisfy 2^SLICE_W > NUM_SLICES
ADDR_W, 11, width of readin_address and sumout_address
IDX_W, 16, width of sample_index (two's complement)
NUM_FRAMES, 2048, read-in addresses consumed per accumulation run
DEPTH, 2048, sum-buffer entries read out; must be <= 2^ADDR_W
READ_LAT, 2, BRAM read latency; sample_index starts at -READ_LAT
STRIDE, 2, clocks each sumout_address is held during readout (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle request to begin a run; honoured only in IDLE
abort  in  1  synchronous cancel; returns to IDLE next cycle
usedataflag  in  1  datapath flag; each falling edge advances sumout_address during ACCUM
slice_state  out  SLICE_W  current slice slot to the datapath
sample_index  out  IDX_W  current sample index (signed)
readin_address  out  ADDR_W  input BRAM address
readinen  out  1  read-in enable
sumout_address  out  ADDR_W  sum-buffer address
sumouten  out  1  sum-buffer output enable
busy  out  1  high in ACCUM and READOUT
done  out  1  one-cycle pulse at end of readout

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on rst.
- All outputs are registered.
- Reset values: state IDLE, slice_state 0, sample_index -READ_LAT, readin_address 0, sumout_address 0, readinen 0, sumouten 0, busy 0, done 0.
- States: IDLE, ACCUM, READOUT, DONE.
- IDLE -> ACCUM on the clock edge sampling start=1.
  - From the next cycle: busy=1, readinen=1.
  - slice_state sequence 0,1,..,NUM_SLICES,0,...
- In ACCUM, each cycle:
  - sample_index += 1 when slice_state != 0.
  - readin_address += 1 when slice_state == NUM_SLICES.
- ACCUM -> READOUT after the cycle with slice_state == NUM_SLICES and readin_address == NUM_FRAMES-1.
  - Duration is exactly NUM_FRAMES*(NUM_SLICES+1) cycles.
  - On the transition, readin_address is held at NUM_FRAMES-1, not incremented.
- usedataflag edge detect:
  - Synchronous; a falling edge is prev=1, cur=0.
  - sumout_address increments one cycle after the sampled falling edge, in ACCUM only.
  - Wraps modulo DEPTH.
  - Falling edges seen in IDLE or READOUT are ignored.
- Entering READOUT:
  - readinen=0, sumouten=1, sumout_address=0, slice_state=0.
  - sample_index holds its last value.
- In READOUT:
  - Each address is held STRIDE cycles, then increments.
  - After address DEPTH-1 has been held STRIDE cycles, go to DONE.
- DONE lasts one cycle:
  - done=1, busy=0, sumouten=0.
  - Next cycle: IDLE, with counters restored to their reset values.
- start while busy or in DONE is ignored.
- abort in any state:
  - Next cycle equals the reset state; done is not asserted.
  - abort and start in the same cycle: abort wins.
- rst asserted mid-run forces the reset values immediately (asynchronous), with no pulse on done.
- sample_index wraps in two's complement at 2^IDX_W; no saturation.

Decomposition:
- Shared package beamformer_pkg holds:
  - slice-state constants SLICE_IDLE=0 and the 1-based slice numbering;
  - controller state encoding (IDLE/ACCUM/READOUT/DONE);
  - the default widths ADDR_W=11, IDX_W=16, SLICE_W=2.
- One natural sub-module, beamform_slice_counter. It owns the slice_state rotation, the sample_index counter and the readin_address counter, with enable, clear and last-frame outputs.
- The top owns the FSM, edge detect, and readout address/stride counter.

Test Plan:
1. NUM_SLICES=3, NUM_FRAMES=4, DEPTH=8, STRIDE=2, READ_LAT=2; release rst, pulse start -> busy 1 for 16 ACCUM cycles; slice_state 0,1,2,3 repeating; final sample_index 10; readin_address ends at 3.
2. Same config, readout -> sumout_address 0..7 each held 2 cycles (16 cycles), sumouten 1 throughout, then done high for exactly 1 cycle, then IDLE with sample_index -2.
3. During ACCUM toggle usedataflag 1->0 three times -> sumout_address reads 3, each step one cycle after the sampled falling edge; a 1->0 edge during IDLE leaves it at 0.
4. abort asserted at the 5th ACCUM cycle -> next cycle all outputs equal reset values, done never pulses; a subsequent start gives a full, correct run.
5. start re-pulsed during ACCUM and READOUT -> no effect on counters or run length; start and abort together in IDLE -> stays IDLE.
6. rst asserted asynchronously mid-READOUT (sumout_address 5) -> outputs return to reset values before the next clk edge; no done pulse.
